// File: rtl/adc_spi_responder_pkg.sv
// Shared types and constants for the serial ADC emulator: FSM states,
// control-word bit positions and sample coding helpers.
package adc_spi_responder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam int WRITE_BIT  = 15;
  localparam int SEQ_BIT    = 14;
  localparam int ADD2_BIT   = 12;
  localparam int ADD0_BIT   = 10;
  localparam int PM1_BIT    = 9;
  localparam int PM0_BIT    = 8;
  localparam int SHADOW_BIT = 7;
  localparam int RANGE_BIT  = 5;
  localparam int CODING_BIT = 4;

  localparam int FRAME_BITS_DEFAULT = 16;

  // CODING=0 returns two's complement, which for a mid-scale-offset unsigned
  // sample is just the MSB inverted.
  function automatic logic [11:0] code_sample(input logic [11:0] s, input logic straight);
    return straight ? s : {~s[11], s[10:0]};
  endfunction

  // Control register holds word bits [15:4]; PM defaults to 11 (normal operation).
  function automatic logic [11:0] ctrl_reset(input logic coding);
    return {1'b0, 2'b00, 3'b000, 2'b11, 2'b00, 1'b0, coding};
  endfunction

endpackage

// File: rtl/adc_spi_responder_if.sv
// Serial bus between the capture-path master and the ADC emulator.
interface adc_spi_responder_if;
  logic SCLK;
  logic CSN;
  logic DIN;
  logic DOUT;
  logic DOUT_oe;

  modport master (output SCLK, output CSN, output DIN, input DOUT, input DOUT_oe);
  modport slave  (input SCLK, input CSN, input DIN, output DOUT, output DOUT_oe);
endinterface

// File: rtl/adc_spi_responder_input_sync.sv
// Multi-flop synchronizer with one extra history flop so rise/fall pulses
// come from the last two stages.
module adc_spi_responder_input_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES:0] r_sh;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_sh <= {(SYNC_STAGES+1){RST_VAL}};
    else       r_sh <= {r_sh[SYNC_STAGES-1:0], i_d};
  end

  assign o_level = r_sh[SYNC_STAGES-1];
  assign o_rise  =  r_sh[SYNC_STAGES-1] & ~r_sh[SYNC_STAGES];
  assign o_fall  = ~r_sh[SYNC_STAGES-1] &  r_sh[SYNC_STAGES];

endmodule

// File: rtl/adc_spi_responder.sv
// AD7928-style serial ADC emulator: decodes the 16-bit control word on DIN
// and returns {0, ADD[2:0], D[11:0]} on DOUT, all oversampled on CLOCK_50.
module adc_spi_responder
  import adc_spi_responder_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   FRAME_BITS  = FRAME_BITS_DEFAULT,
  parameter logic RST_CODING  = 1'b0
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  adc_spi_responder_if.slave  spi,
  output logic [2:0]          sample_addr,
  input  logic [11:0]         sample_data,
  output logic                frame_done,
  output logic                frame_abort,
  output logic [11:0]         ctrl_reg
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_SHIFT = SHIFT;
  localparam logic [1:0] S_HOLD  = HOLD;
  localparam logic [4:0] LAST_EDGE = 5'(FRAME_BITS - 1);

  logic w_sclk_level, w_sclk_rise, w_sclk_fall;
  logic w_csn_level, w_csn_rise, w_csn_fall;
  logic w_din, w_din_rise, w_din_fall;
  logic w_unused;

  adc_spi_responder_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sclk (
    .i_clk(CLOCK_50), .i_rst(reset), .i_d(spi.SCLK),
    .o_level(w_sclk_level), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall));
  adc_spi_responder_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csn (
    .i_clk(CLOCK_50), .i_rst(reset), .i_d(spi.CSN),
    .o_level(w_csn_level), .o_rise(w_csn_rise), .o_fall(w_csn_fall));
  adc_spi_responder_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_din (
    .i_clk(CLOCK_50), .i_rst(reset), .i_d(spi.DIN),
    .o_level(w_din), .o_rise(w_din_rise), .o_fall(w_din_fall));

  assign w_unused = &{1'b0, w_sclk_level, w_sclk_rise, w_csn_level, w_din_rise, w_din_fall};

  logic [1:0]  r_state;
  logic [4:0]  r_n;
  logic        r_dout;
  logic        r_oe;
  logic [2:0]  r_addr;
  logic        r_done;
  logic        r_abort;
  logic [11:0] r_ctrl;
  logic [14:0] r_tx;
  logic [14:0] r_rx;
  logic [15:0] w_tx_load;
  logic [15:0] w_rx_next;
  logic        w_start;
  logic        w_shift;

  assign w_tx_load = {1'b0, r_addr, code_sample(sample_data, r_ctrl[CODING_BIT-4])};
  assign w_rx_next = {r_rx, w_din};
  assign w_start   = (r_state == S_IDLE)  && w_csn_fall;
  assign w_shift   = (r_state == S_SHIFT) && w_sclk_fall;

  // Control path: FSM, edge count, output pin and committed control state
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_n     <= '0;
      r_dout  <= 1'b0;
      r_oe    <= 1'b0;
      r_addr  <= '0;
      r_done  <= 1'b0;
      r_abort <= 1'b0;
      r_ctrl  <= ctrl_reset(RST_CODING);
    end else begin
      r_done  <= 1'b0;
      r_abort <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_csn_fall) begin
            r_state <= S_SHIFT;
            r_oe    <= 1'b1;
            r_dout  <= w_tx_load[15];
            r_n     <= '0;
          end
        end
        S_SHIFT: begin
          // A CSN rise coinciding with the final edge still completes the frame
          if (w_sclk_fall && r_n == LAST_EDGE) begin
            r_n    <= r_n + 5'd1;
            r_dout <= 1'b0;
            r_done <= 1'b1;
            if (w_rx_next[WRITE_BIT]) begin
              r_ctrl <= w_rx_next[15:4];
              r_addr <= w_rx_next[ADD2_BIT:ADD0_BIT];
            end
            if (w_csn_rise) begin
              r_state <= S_IDLE;
              r_oe    <= 1'b0;
            end else begin
              r_state <= S_HOLD;
            end
          end else if (w_csn_rise) begin
            r_state <= S_IDLE;
            r_oe    <= 1'b0;
            r_dout  <= 1'b0;
            r_abort <= 1'b1;
          end else if (w_sclk_fall) begin
            r_n    <= r_n + 5'd1;
            r_dout <= r_tx[14];
          end
        end
        S_HOLD: begin
          if (w_csn_rise) begin
            r_state <= S_IDLE;
            r_oe    <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Data path: transmit and receive shift registers, reloaded every frame
  always_ff @(posedge CLOCK_50) begin
    if (w_start)      r_tx <= w_tx_load[14:0];
    else if (w_shift) r_tx <= {r_tx[13:0], 1'b0};
    if (w_shift)      r_rx <= w_rx_next[14:0];
  end

  assign spi.DOUT    = r_dout;
  assign spi.DOUT_oe = r_oe;
  assign sample_addr = r_addr;
  assign frame_done  = r_done;
  assign frame_abort = r_abort;
  assign ctrl_reg    = r_ctrl;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for the serial ADC emulator: table of full frames plus
// hand-written abort, overlong, simultaneous-edge and mid-frame reset cases.
module tb_adc_spi_responder;
  import adc_spi_responder_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  sample_addr;
  logic [11:0] sample_data;
  logic        frame_done;
  logic        frame_abort;
  logic [11:0] ctrl_reg;

  adc_spi_responder_if spi();

  adc_spi_responder #(.SYNC_STAGES(2), .FRAME_BITS(16), .RST_CODING(1'b0)) dut (
    .CLOCK_50(clk), .reset(reset), .spi(spi),
    .sample_addr(sample_addr), .sample_data(sample_data),
    .frame_done(frame_done), .frame_abort(frame_abort), .ctrl_reg(ctrl_reg));

  always #10 clk = ~clk;

  int done_tot  = 0;
  int abort_tot = 0;
  always @(negedge clk) begin
    if (frame_done)  done_tot  <= done_tot + 1;
    if (frame_abort) abort_tot <= abort_tot + 1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives DIN MSB first, reads DOUT just before each SCLK fall; leaves CSN low
  // unless csn_last raises it together with the final falling edge.
  task automatic run_frame(input logic [15:0] din, input logic [11:0] sd, input int nedges,
                           input bit csn_last, output logic [15:0] got);
    got = '0;
    sample_data = sd;
    spi.DIN = din[15];
    #100;
    spi.CSN = 1'b0;
    #200;
    for (int i = 0; i < nedges; i++) begin
      if (i < 16) got[15-i] = spi.DOUT;
      spi.SCLK = 1'b0;
      if (csn_last && i == nedges - 1) spi.CSN = 1'b1;
      #100;
      spi.SCLK = 1'b1;
      spi.DIN = (i < 15) ? din[14-i] : 1'b1;
      #100;
    end
  endtask

  task automatic end_frame();
    spi.CSN = 1'b1;
    #200;
  endtask

  typedef struct {
    logic [15:0] din;
    logic [11:0] sd;
    logic [15:0] dout;
    logic [11:0] ctrl;
    logic [2:0]  addr;
  } vec_t;

  vec_t tbl[4];
  logic [15:0] got;
  int d0, a0;

  initial begin
    tbl[0] = '{din: 16'h8F00, sd: 12'hABC, dout: 16'h02BC, ctrl: 12'h8F0, addr: 3'd3};
    tbl[1] = '{din: 16'h0000, sd: 12'h123, dout: 16'h3923, ctrl: 12'h8F0, addr: 3'd3};
    tbl[2] = '{din: 16'h8010, sd: 12'h456, dout: 16'h3C56, ctrl: 12'h801, addr: 3'd0};
    tbl[3] = '{din: 16'h0000, sd: 12'hFFF, dout: 16'h0FFF, ctrl: 12'h801, addr: 3'd0};

    reset = 1'b1;
    spi.SCLK = 1'b1;
    spi.CSN = 1'b1;
    spi.DIN = 1'b0;
    sample_data = '0;
    #15;
    check("rst_dout", 32'(spi.DOUT), 32'h0);
    check("rst_oe", 32'(spi.DOUT_oe), 32'h0);
    check("rst_addr", 32'(sample_addr), 32'h0);
    check("rst_ctrl", 32'(ctrl_reg), 32'h030);
    check("rst_pulses", 32'({frame_done, frame_abort}), 32'h0);
    #85;
    reset = 1'b0;
    #200;

    for (int k = 0; k < 4; k++) begin
      d0 = done_tot;
      a0 = abort_tot;
      run_frame(tbl[k].din, tbl[k].sd, 16, 1'b0, got);
      check($sformatf("tbl%0d_dout", k), 32'(got), 32'(tbl[k].dout));
      check($sformatf("tbl%0d_oe_hold", k), 32'(spi.DOUT_oe), 32'h1);
      end_frame();
      check($sformatf("tbl%0d_ctrl", k), 32'(ctrl_reg), 32'(tbl[k].ctrl));
      check($sformatf("tbl%0d_addr", k), 32'(sample_addr), 32'(tbl[k].addr));
      check($sformatf("tbl%0d_done", k), 32'(done_tot - d0), 32'h1);
      check($sformatf("tbl%0d_abort", k), 32'(abort_tot - a0), 32'h0);
      check($sformatf("tbl%0d_oe_idle", k), 32'(spi.DOUT_oe), 32'h0);
    end

    // Abort after 9 edges, with exact output-enable latency
    d0 = done_tot;
    a0 = abort_tot;
    run_frame(16'h8F11, 12'h777, 9, 1'b0, got);
    check("abort_oe_before", 32'(spi.DOUT_oe), 32'h1);
    spi.CSN = 1'b1;
    #40;
    check("abort_oe_early", 32'(spi.DOUT_oe), 32'h1);
    #30;
    check("abort_oe_off", 32'(spi.DOUT_oe), 32'h0);
    #130;
    check("abort_pulse", 32'(abort_tot - a0), 32'h1);
    check("abort_no_done", 32'(done_tot - d0), 32'h0);
    check("abort_ctrl", 32'(ctrl_reg), 32'h801);
    check("abort_addr", 32'(sample_addr), 32'h0);

    // 20 edges: commit at edge 16, extra edges ignored
    d0 = done_tot;
    run_frame(16'h8C00, 12'h5A5, 20, 1'b0, got);
    check("long_dout", 32'(got), 32'h05A5);
    check("long_dout_zero", 32'(spi.DOUT), 32'h0);
    check("long_oe_hold", 32'(spi.DOUT_oe), 32'h1);
    check("long_done_once", 32'(done_tot - d0), 32'h1);
    check("long_ctrl", 32'(ctrl_reg), 32'h8C0);
    end_frame();
    check("long_addr", 32'(sample_addr), 32'h3);
    check("long_oe_idle", 32'(spi.DOUT_oe), 32'h0);

    // CSN rise together with the 16th falling edge completes the frame
    d0 = done_tot;
    a0 = abort_tot;
    run_frame(16'h8410, 12'h800, 16, 1'b1, got);
    #200;
    check("simul_dout", 32'(got), 32'h3000);
    check("simul_done", 32'(done_tot - d0), 32'h1);
    check("simul_no_abort", 32'(abort_tot - a0), 32'h0);
    check("simul_ctrl", 32'(ctrl_reg), 32'h841);
    check("simul_addr", 32'(sample_addr), 32'h1);
    check("simul_oe", 32'(spi.DOUT_oe), 32'h0);

    // Asynchronous reset at edge 7, then a clean frame as the first one
    run_frame(16'h0000, 12'h111, 7, 1'b0, got);
    reset = 1'b1;
    #1;
    check("mrst_oe", 32'(spi.DOUT_oe), 32'h0);
    check("mrst_dout", 32'(spi.DOUT), 32'h0);
    check("mrst_ctrl", 32'(ctrl_reg), 32'h030);
    check("mrst_addr", 32'(sample_addr), 32'h0);
    spi.CSN = 1'b1;
    spi.DIN = 1'b0;
    #99;
    reset = 1'b0;
    #200;
    d0 = done_tot;
    run_frame(tbl[0].din, tbl[0].sd, 16, 1'b0, got);
    end_frame();
    check("post_rst_dout", 32'(got), 32'(tbl[0].dout));
    check("post_rst_ctrl", 32'(ctrl_reg), 32'(tbl[0].ctrl));
    check("post_rst_addr", 32'(sample_addr), 32'(tbl[0].addr));
    check("post_rst_done", 32'(done_tot - d0), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
